// File: rtl/cache_pkg.sv
// cache_pkg
// Shared definitions for the cache data-bank datapath: the line geometry,
// the line-reader state encoding and the helper that locates one
// (bank, way) word inside the flattened bank read-data bus.
// No ports (package).
package cache_pkg;

  localparam int SET_W  = 8;   // set index width (256 sets)
  localparam int WAYS   = 4;   // associativity, width of the way one-hot
  localparam int BANKS  = 4;   // banks per line, one word per bank
  localparam int DATA_W = 32;  // word width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2
  } reader_state_t;

  // LSB position of bank b, way w inside the flattened bank read-data bus.
  function automatic int bank_word_lsb(input int bank, input int way,
                                       input int ways, input int data_w);
    return (bank * ways + way) * data_w;
  endfunction

endpackage

// File: rtl/line_way_select.sv
// line_way_select
// Combinational per-bank AND-OR way mux. For every bank it ORs together the
// words of all ways whose bit is set in 'way'. A one-hot 'way' gives a plain
// mux; zero gives an all-zero line; multi-hot gives the OR of the ways.
// Ports:
//   way        in  WAYS               way select (normally one-hot)
//   bank_data  in  BANKS*WAYS*DATA_W  flattened bank read data
//   line       out BANKS*DATA_W       selected line, bank 0 in the low word
module line_way_select #(
  parameter int WAYS   = cache_pkg::WAYS,
  parameter int BANKS  = cache_pkg::BANKS,
  parameter int DATA_W = cache_pkg::DATA_W
) (
  input  logic [WAYS-1:0]              way,
  input  logic [BANKS*WAYS*DATA_W-1:0] bank_data,
  output logic [BANKS*DATA_W-1:0]      line
);
  import cache_pkg::*;

  always_comb begin
    line = '0;
    for (int b = 0; b < BANKS; b++) begin
      for (int w = 0; w < WAYS; w++) begin
        if (way[w]) begin
          line[b*DATA_W +: DATA_W] = line[b*DATA_W +: DATA_W]
                                   | bank_data[bank_word_lsb(b, w, WAYS, DATA_W) +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/data_bank_line_reader.sv
// data_bank_line_reader
// Read-side initiator for the cache data banks. Takes a (set, way) line-read
// request, drives the shared bank read set, captures the selected way's line
// one cycle later and streams it word by word on a valid/ready channel.
// Optional: define DATA_BANK_READER_STALL_CNT_EN to add perf_stall_cnt, a
// saturating count of cycles with out_valid && !out_ready.
// Ports:
//   clock, reset (async, active-low)
//   req_valid/req_ready/req_set/req_way   line-read request
//   bank_r_set  out  read set to all banks (1-cycle bank read latency)
//   bank_r_data in   flattened bank data, bank b way w at (b*WAYS+w)*DATA_W
//   out_valid/out_ready/out_data/out_idx/out_last   beat stream
//   busy        out  reader not idle
//   perf_stall_cnt out [15:0] (only with the macro defined)
module data_bank_line_reader #(
  parameter int SET_W  = cache_pkg::SET_W,
  parameter int WAYS   = cache_pkg::WAYS,
  parameter int BANKS  = cache_pkg::BANKS,
  parameter int DATA_W = cache_pkg::DATA_W,
  localparam int IDX_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [SET_W-1:0]             req_set,
  input  logic [WAYS-1:0]              req_way,
  output logic [SET_W-1:0]             bank_r_set,
  input  logic [BANKS*WAYS*DATA_W-1:0] bank_r_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [IDX_W-1:0]             out_idx,
  output logic                         out_last,
`ifdef DATA_BANK_READER_STALL_CNT_EN
  output logic [15:0]                  perf_stall_cnt,
`endif
  output logic                         busy
);
  import cache_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BANKS - 1);

  reader_state_t     state, next_state;
  logic [SET_W-1:0]  set_reg;
  logic [WAYS-1:0]   way_reg;
  logic [DATA_W-1:0] buffer [BANKS];
  logic [IDX_W-1:0]  cnt;
  logic [BANKS*DATA_W-1:0] line;
  logic              at_last;

  assign at_last = (cnt == LAST_IDX);

  // Way mux works on the latched way so the capture in READ is independent
  // of whatever the requester drives after the handshake.
  line_way_select #(
    .WAYS  (WAYS),
    .BANKS (BANKS),
    .DATA_W(DATA_W)
  ) u_way_select (
    .way      (way_reg),
    .bank_data(bank_r_data),
    .line     (line)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = READ;
      READ:    next_state = SEND;
      SEND:    if (out_ready && at_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs. In IDLE the request set goes straight to the banks so the read
  // overlaps the handshake cycle; otherwise the latched set keeps the bank
  // inputs quiet.
  always_comb begin
    req_ready  = (state == IDLE);
    busy       = (state != IDLE);
    bank_r_set = (state == IDLE) ? req_set : set_reg;
    out_valid  = (state == SEND);
    out_data   = (state == SEND) ? buffer[cnt] : '0;
    out_idx    = (state == SEND) ? cnt : '0;
    out_last   = (state == SEND) && at_last;
  end

  // Request latch, line capture and beat counter. The buffer freezes the line
  // at capture so later bank writes cannot leak into a transfer in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      set_reg <= '0;
      way_reg <= '0;
      cnt     <= '0;
      for (int b = 0; b < BANKS; b++) begin
        buffer[b] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            set_reg <= req_set;
            way_reg <= req_way;
          end
        end
        READ: begin
          cnt <= '0;
          for (int b = 0; b < BANKS; b++) begin
            buffer[b] <= line[b*DATA_W +: DATA_W];
          end
        end
        SEND: begin
          if (out_ready && !at_last) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DATA_BANK_READER_STALL_CNT_EN
  // Saturating stall counter, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (perf_stall_cnt != 16'hFFFF)) begin
      perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
